// File: rtl/ascon_inv_diffusion_if.sv
// Start/done handshake and state buses for the inverse ASCON diffusion block.
// Both state buses are in type_state layout: five 64-bit words, word i at [i].
interface ascon_inv_diffusion_if;
  logic              start_i;
  logic [4:0][63:0]  state_i;
  logic              busy_o;
  logic              done_o;
  logic [4:0][63:0]  state_o;

  // Requester side: issues start with a diffused state and collects the result.
  modport master (
    output start_i,
    output state_i,
    input  busy_o,
    input  done_o,
    input  state_o
  );

  // Block side: inverts the diffusion layer.
  modport slave (
    input  start_i,
    input  state_i,
    output busy_o,
    output done_o,
    output state_o
  );
endinterface

// File: rtl/ascon_inv_diffusion.sv
// Iterative inverse of the ASCON linear diffusion layer p_L.
// Sigma_i^-1 = Sigma_i^63 is computed as six squaring steps S_0..S_5, one per
// cycle. In S_k the rotation amounts are (a_i * 2^k) mod 64. All thirty
// amounts are constants, so each step is plain wiring. A 6-way mux selects
// the step for the current cycle.
module ascon_inv_diffusion (
  input  logic                 clock_i,
  input  logic                 reset_i,
  ascon_inv_diffusion_if.slave bus
);

  typedef logic [4:0][63:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // ASCON forward rotation pairs (a_i, b_i), one pair per state word.
  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};
  localparam logic [2:0]  LAST_STEP = 3'd5;

  // Right rotation. The callers pass only constants, so this becomes wiring.
  // An amount of 0 returns x unchanged.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    logic [127:0] dbl;
    dbl = {x, x} >> n;
    return dbl[63:0];
  endfunction

  fsm_e        state_q, state_d;
  logic [2:0]  k_q, k_d;
  state_t      work_q, work_d;
  state_t      out_q, out_d;
  state_t      step_res;
  logic [63:0] cand [5][6];

  // Each word has six step results, each with hard-wired rotation amounts.
  // When a rotation amount is 0, the x term cancels against itself.
  for (genvar gi = 0; gi < 5; gi++) begin : g_word
    for (genvar gk = 0; gk < 6; gk++) begin : g_step
      localparam int unsigned RA = (ROT_A[gi] << gk) % 64;
      localparam int unsigned RB = (ROT_B[gi] << gk) % 64;
      assign cand[gi][gk] = work_q[gi] ^ rotr(work_q[gi], RA) ^ rotr(work_q[gi], RB);
    end
  end

  // Select the result of step k for every word.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      case (k_q)
        3'd0:    step_res[i] = cand[i][0];
        3'd1:    step_res[i] = cand[i][1];
        3'd2:    step_res[i] = cand[i][2];
        3'd3:    step_res[i] = cand[i][3];
        3'd4:    step_res[i] = cand[i][4];
        3'd5:    step_res[i] = cand[i][5];
        default: step_res[i] = work_q[i];
      endcase
    end
  end

  // State register plus datapath registers. Reset clears the whole state.
  always_ff @(posedge clock_i) begin
    // NOTE: the 320-bit work and result registers are reset along with the FSM.
    // This makes an aborted run leave state_o at zero with no stale data.
    if (reset_i) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from
      // values sampled before the edge.
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic. Start is accepted only from IDLE or DONE.
  always_comb begin
    // NOTE: every signal gets a default value here, so paths that do not
    // assign it cannot infer a latch.
    state_d = state_q;
    k_d     = k_q;
    work_d  = work_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          work_d  = bus.state_i;
          k_d     = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = step_res;
        k_d    = k_q + 3'd1;
        if (k_q == LAST_STEP) begin
          out_d   = step_res;
          k_d     = 3'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start_i) begin
          work_d  = bus.state_i;
          k_d     = 3'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // Outputs are decoded only from registers. No input reaches an output.
  always_comb begin
    bus.busy_o  = (state_q == RUN);
    bus.done_o  = (state_q == DONE);
    bus.state_o = out_q;
  end

endmodule

// File: tb/tb_ascon_inv_diffusion.sv
// Bench for ascon_inv_diffusion. Stimulus pushes expected results into a
// scoreboard queue, and a monitor checks them on each done_o pulse.
// The reference model inverts Sigma by applying it 63 times, because
// Sigma^64 is the identity.
module tb_ascon_inv_diffusion;

  typedef logic [4:0][63:0] state_t;

  typedef struct {
    bit     via_fwd;  // if set, compare diffusion(state_o) against ref_val
    state_t ref_val;
    string  name;
  } exp_t;

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   pushed = 0;
  int   done_seen = 0;
  exp_t sb_q[$];

  state_t v1, v2;

  ascon_inv_diffusion_if bus ();

  ascon_inv_diffusion dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    int k;
    k = n % 64;
    if (k == 0) return x;
    return (x >> k) | (x << (64 - k));
  endfunction

  function automatic logic [63:0] sigma(input logic [63:0] x, input int i);
    return x ^ rotr64(x, ROT_A[i]) ^ rotr64(x, ROT_B[i]);
  endfunction

  function automatic state_t fwd_model(input state_t s);
    state_t r;
    for (int i = 0; i < 5; i++) r[i] = sigma(s[i], i);
    return r;
  endfunction

  function automatic state_t inv_model(input state_t s);
    state_t r;
    for (int i = 0; i < 5; i++) begin
      logic [63:0] y;
      y = s[i];
      for (int j = 0; j < 63; j++) y = sigma(y, i);
      r[i] = y;
    end
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic check_state(input string name, input state_t act, input state_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit via_fwd, input state_t ref_val, input string name);
    exp_t e;
    e.via_fwd = via_fwd;
    e.ref_val = ref_val;
    e.name    = name;
    sb_q.push_back(e);
    pushed++;
  endtask

  // Monitor: on every done_o pulse, take the oldest expectation and compare.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.done_o === 1'b1) begin
      done_seen++;
      check_bit("done_has_pending_request", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (e.via_fwd) check_state({e.name, "_roundtrip"}, fwd_model(bus.state_o), e.ref_val);
        else           check_state(e.name, bus.state_o, e.ref_val);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Entry: #1 after a rising edge, DUT in IDLE. Exit: same position, 8 cycles later.
  task automatic run_single(input string name, input state_t x, input bit via_fwd,
                            input state_t ref_val, input bit poke_start);
    bus.state_i = x;
    bus.start_i = 1'b1;
    push_exp(via_fwd, ref_val, name);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.state_i = rand_state();
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      check_bit({name, "_busy"}, bus.busy_o, n <= 6);
      check_bit({name, "_done"}, bus.done_o, n == 7);
      if (poke_start) begin
        bus.start_i = (n == 2) || (n == 5);
        bus.state_i = rand_state();
      end
    end
    @(posedge clk); #1;
    check_bit({name, "_idle_busy"}, bus.busy_o, 1'b0);
    check_bit({name, "_idle_done"}, bus.done_o, 1'b0);
  endtask

  task automatic back_to_back();
    state_t vecs [2];
    vecs[0] = v1;
    vecs[1] = v2;
    bus.start_i = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus.state_i = fwd_model(vecs[r % 2]);
      push_exp(1'b0, vecs[r % 2], "b2b");
      @(posedge clk); #1;
      for (int n = 1; n <= 6; n++) begin
        bus.state_i = rand_state();
        check_bit("b2b_busy", bus.busy_o, 1'b1);
        check_bit("b2b_done_low", bus.done_o, 1'b0);
        @(posedge clk); #1;
      end
      check_bit("b2b_done_pulse", bus.done_o, 1'b1);
      check_bit("b2b_busy_in_done", bus.busy_o, 1'b0);
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check_bit("b2b_end_idle", bus.busy_o, 1'b0);
  endtask

  task automatic reset_mid_run();
    bus.state_i = fwd_model(v1);
    bus.start_i = 1'b1;                       // cycle c
    @(posedge clk); #1;                       // c+1
    bus.start_i = 1'b0;
    @(posedge clk); #1;                       // c+2
    @(posedge clk); #1;                       // c+3
    rst = 1'b1;
    @(posedge clk); #1;                       // c+4
    rst = 1'b0;
    check_bit("rst_mid_busy", bus.busy_o, 1'b0);
    check_bit("rst_mid_done", bus.done_o, 1'b0);
    check_state("rst_mid_state_o", bus.state_o, '0);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check_bit("rst_mid_no_done", bus.done_o, 1'b0);
    end
    run_single("after_reset_v2", fwd_model(v2), 1'b0, v2, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    state_t x;
    v1[0] = 64'h25f7c341c45f9912; v1[1] = 64'h23b794c540876856;
    v1[2] = 64'hb85451593d679610; v1[3] = 64'h4fafba264a9e49ba;
    v1[4] = 64'h62b54d5d460aded4;
    v2[0] = 64'h94d8684872579d47; v2[1] = 64'h44806ada0a028aa5;
    v2[2] = 64'h8df8ebd050856918; v2[3] = 64'he12b4270c43159c2;
    v2[4] = 64'h61325cbd80ab1b2c;

    bus.start_i = 1'b0;
    bus.state_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_bit("reset_busy", bus.busy_o, 1'b0);
    check_bit("reset_done", bus.done_o, 1'b0);
    check_state("reset_state_o", bus.state_o, '0);
    @(posedge clk); #1;

    run_single("zero", '0, 1'b0, '0, 1'b0);
    run_single("rt_v1", fwd_model(v1), 1'b0, v1, 1'b0);
    run_single("rt_v2", fwd_model(v2), 1'b0, v2, 1'b0);
    run_single("rev_v1", v1, 1'b1, v1, 1'b0);
    run_single("rev_v2", v2, 1'b1, v2, 1'b0);
    for (int t = 0; t < 6; t++) begin
      x = rand_state();
      run_single("rand_inv", x, 1'b0, inv_model(x), 1'b0);
    end
    for (int t = 0; t < 3; t++) begin
      x = rand_state();
      run_single("rand_rev", x, 1'b1, x, 1'b0);
    end
    run_single("ignored_start", fwd_model(v1), 1'b0, v1, 1'b1);
    back_to_back();
    reset_mid_run();

    repeat (10) @(posedge clk);
    #1;
    check_int("scoreboard_empty", sb_q.size(), 0);
    check_int("done_count", done_seen, pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ascon_inv_diffusion.md
# ascon_inv_diffusion

Iterative inverse of the ASCON linear diffusion layer (the p_L layer). It takes a 320-bit state in `type_state` format, runs a fixed 6-cycle computation, and returns the state that the `diffusion` module would map back to the input. It sits on the decryption/verification side of the permutation datapath and gives the team a hardware round-trip check for `diffusion`. It uses a start/done handshake, one 64-bit datapath per state word, and a 3-bit step counter.

## Interface
- No parameters. The rotation constants are fixed by ASCON.
- `clock_i` in, 1: single clock. All logic is on the rising edge.
- `reset_i` in, 1: synchronous, active-high reset.
- `start_i` in, 1: request. Sampled only when `busy_o`=0.
- `state_i` in, `type_state` (5×64): diffused state. Captured on an accepted start.
- `busy_o` out, 1: high while a computation is in progress.
- `done_o` out, 1: one-cycle pulse when `state_o` becomes valid.
- `state_o` out, `type_state` (5×64): inverse-diffused state. Held until the next accepted start.

## Operation
- The forward layer is, per word i, Σi(x) = x ^ (x>>>a_i) ^ (x>>>b_i), with right rotations:
  - (a0,b0)=(19,28)
  - (a1,b1)=(61,39)
  - (a2,b2)=(1,6)
  - (a3,b3)=(10,17)
  - (a4,b4)=(7,41)
- Inversion method: Σi^-1 = Σi^63 = the product over k=0..5 of steps S_k. Each step is S_k(x) = x ^ (x>>>((a_i·2^k) mod 64)) ^ (x>>>((b_i·2^k) mod 64)).
  - Step k applies to all 5 words in parallel, each with its own constants.
  - The steps commute, but the order is fixed at k=0→5.
- Rotation amounts are computed mod 64. An amount of 0 means "x itself" and must cancel correctly.
  - Example: word 2 at k=5 gives rotations 32 and 0, so S_5 = x>>>32.
  - Amounts may be hard-wired per step through a 6-way mux. No variable barrel shifter is required.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: if start_i=1, load the work register from state_i, set k=0, go to RUN.
  - RUN: each edge does work ← S_k(work) and k ← k+1. After the edge that applies k=5, copy work to state_o and go to DONE.
  - DONE: done_o=1 for this single cycle.
    - If start_i=1 in DONE, it is accepted: load state_i, set k=0, go to RUN.
    - Otherwise go to IDLE.
- busy_o=1 exactly in RUN. done_o=1 exactly in DONE.
- start_i is ignored in RUN. state_i is not sampled there and the computation is not disturbed.
- state_o updates only on the RUN→DONE transition and holds its value through IDLE and subsequent RUN phases.
- Reset (any state, including mid-RUN) has priority over everything:
  - next state = IDLE, k=0, work register=0, state_o=0, busy_o=0, done_o=0.
  - An aborted computation never produces done_o.

## Timing
- Cycle c: start_i=1 and busy_o=0, so state_i is captured at the end of c.
- Cycles c+1 … c+6: busy_o=1, applying k=0…5.
- Cycle c+7: done_o=1 and state_o is valid. Latency is 7 cycles from the accepting cycle.
- Throughput with start_i held high: one result every 7 cycles, with no idle cycle between results. DONE accepts directly.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Output values after reset release: busy_o=0, done_o=0, state_o=all zeros.

## Test plan
- Zero state: state_i all 0, pulse start_i.
  - Required: done_o at cycle c+7, state_o all 0, busy_o high for exactly 6 cycles.
- Round trip, vector 1: drive `diffusion` with {25f7c341c45f9912, 23b794c540876856, b85451593d679610, 4fafba264a9e49ba, 62b54d5d460aded4} and feed its output into this block.
  - Required: state_o equals those five input words exactly.
- Round trip, vector 2: the same check with {94d8684872579d47, 44806ada0a028aa5, 8df8ebd050856918, e12b4270c43159c2, 61325cbd80ab1b2c}.
  - Required: exact recovery of all five words.
  - Also run the reverse order (this block first, then `diffusion`) and require the identity.
- Back-to-back: hold start_i=1 and change state_i between vectors 1 and 2 each accepted cycle.
  - Required: done_o pulses every 7 cycles, each state_o matches its own vector, and a state_i change during RUN has no effect.
- Reset mid-run: assert reset_i for one cycle at cycle c+3 of a vector-1 computation.
  - Required: busy_o=0, done_o=0 and state_o=0 on the next cycle, and no done_o pulse follows.
  - A new start afterwards produces the correct vector-2 result.
- Ignored start: pulse start_i at cycles c+2 and c+5 of a run.
  - Required: exactly one done_o at c+7 with the original input's result, then return to IDLE.
